autosa_cmac_reg_initiator: RTL

//  Initiator side of the CMAC register-control interface. Accepts one register-access request at a time (write, read, or poll-until-match).

---
 rtl/autosa_cmac_reg_initiator.sv | 120 ++++++++++++
 1 files changed

// File: rtl/autosa_cmac_reg_initiator.sv
// CMAC register-control initiator: serialises write, read and poll-until-match
// requests onto the responder's offset/strobe/data interface, one response per request.
module autosa_cmac_reg_initiator #(
    parameter int POLL_GAP  = 4,
    parameter int MAX_POLLS = 256,
    parameter int CNT_W     = 9
) (
    input  logic             autosa_core_clk,
    input  logic             autosa_core_rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wr,
    input  logic             req_poll,
    input  logic [11:0]      req_offset,
    input  logic [31:0]      req_wdata,
    input  logic [31:0]      req_mask,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    output logic [CNT_W-1:0] rsp_polls,
    output logic [11:0]      reg_offset,
    output logic             reg_wr_en,
    output logic [31:0]      reg_wr_data,
    input  logic [31:0]      reg_rd_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_POLLS);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

    state_t           state;
    logic             lat_wr;
    logic             lat_poll;
    logic [31:0]      lat_val;
    logic [31:0]      lat_mask;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] gap_cnt;
    logic [CNT_W-1:0] rd_cnt_n;
    logic             hit;

    assign req_ready = (state == IDLE);
    assign rd_cnt_n  = rd_cnt + CNT_W'(1);
    // Only masked bits take part in the poll comparison.
    assign hit       = ((reg_rd_data ^ lat_val) & lat_mask) == 32'd0;

    always_ff @(posedge autosa_core_clk) begin
        if (autosa_core_rst) begin
            state       <= IDLE;
            lat_wr      <= 1'b0;
            lat_poll    <= 1'b0;
            lat_val     <= '0;
            lat_mask    <= '0;
            rd_cnt      <= '0;
            gap_cnt     <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_polls   <= '0;
            reg_offset  <= '0;
            reg_wr_en   <= 1'b0;
            reg_wr_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_wr     <= req_wr;
                        lat_poll   <= req_poll & ~req_wr;
                        lat_val    <= req_wdata;
                        lat_mask   <= req_mask;
                        rd_cnt     <= '0;
                        reg_offset <= req_offset;
                        reg_wr_en  <= req_wr;
                        if (req_wr)
                            reg_wr_data <= req_wdata;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (lat_wr) begin
                        reg_wr_en <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        rsp_polls <= '0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        rd_cnt <= rd_cnt_n;
                        if (!lat_poll || hit || rd_cnt_n == MAX_C) begin
                            rsp_rdata <= reg_rd_data;
                            rsp_err   <= lat_poll && !hit;
                            rsp_polls <= rd_cnt_n;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else if (POLL_GAP == 0) begin
                            state <= ACCESS;
                        end else begin
                            gap_cnt <= '0;
                            state   <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    gap_cnt <= gap_cnt + CNT_W'(1);
                    if (gap_cnt == GAP_LAST)
                        state <= ACCESS;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
